sequence_checker: RTL and testbench
===================================

// Module: sequence_checker
// PURPOSE
//  Round judge for the memory game. Latches the 64-bit encoded target pattern played to the player and decodes it symbol by symbol.
//  Compares each decoded symbol against the player's event codes from the input-type stage.
//  Keeps score and remaining lives, and flags round completion and game over.
//  Sits downstream of the input listeners and beside the display sequencer, consuming the same pattern encoding.
// PARAMETERS
//  LIVES    3  lives restored on reset (1..3)
//  TIMEOUT  0  max clk cycles to wait for a player event; 0 = never time out
//  SCORE_W  8  score counter width
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-low reset
//  load        in   1        1-cycle pulse: latch pattern, start round
//  pattern     in   64       encoded target: leading 0s, then per symbol n 1s + one 0 (n=1 toggle..4 mouse)
//  event_valid in   1        1-cycle strobe, player event present
//  event_code  in   3        player event 1..4; 0 is ignored
//  expected    out  3        symbol currently awaited (0 when not in WAIT_EVT)
//  busy        out  1        high in ALIGN/DECODE/WAIT_EVT
//  match       out  1        1-cycle pulse, correct event
//  mismatch    out  1        1-cycle pulse, wrong event or timeout
//  round_done  out  1        1-cycle pulse, whole pattern matched (or empty pattern)
//  game_over   out  1        level, lives exhausted
//  decode_err  out  1        level, malformed pattern (>4 consecutive 1s)
//  score       out  SCORE_W  matched-symbol count, saturating
//  lives       out  2        remaining lives
// BEHAVIOUR
//  Reset (reset=0 at posedge clk), from any state:
//   - State=IDLE; all pulses, game_over, decode_err = 0.
//   - expected=0, score=0, lives=LIVES.
//  States: IDLE, ALIGN, DECODE, WAIT_EVT, DONE, OVER, ERR.
//  load (any state except OVER): copy pattern to saved reg and shift reg sh; clear ones count and decode_err; next=ALIGN.
//   - load wins over a simultaneous event_valid.
//   - score and lives are kept.
//  ALIGN, one bit per clk:
//   - sh==0: round_done pulse, next=DONE.
//   - else sh[63]==0: sh<<=1.
//   - else (sh[63]==1): next=DECODE, no shift.
//   - Worst case 64 cycles.
//  DECODE, one bit per clk, always sh<<=1:
//   - sh[63]==1: ones++; if ones reaches 5, decode_err=1, next=ERR.
//   - sh[63]==0: expected=ones, ones=0, wait counter=0, next=WAIT_EVT.
//   - Symbol of n 1s takes n+1 cycles.
//  WAIT_EVT:
//   - event_valid with event_code==0 is ignored.
//   - Correct code: match pulse; score+1, saturating at all-ones.
//     - sh==0: round_done pulse, expected=0, next=DONE.
//     - else next=DECODE (sh[63] is already 1).
//   - Wrong code, or TIMEOUT!=0 and wait counter reaches TIMEOUT-1: mismatch pulse; lives-1.
//     - lives was 1: lives=0, game_over=1, next=OVER.
//     - else sh=saved, next=ALIGN (replay from first symbol).
//  event_valid outside WAIT_EVT is ignored; there is no queueing.
//  Pulses are registered: they assert the clk after the causing edge and last exactly 1 cycle.
//  DONE, ERR: hold until load. OVER: hold until reset; load is ignored.
// TESTING
//  - pattern=64'h16 ("10","110"), load; events 1 then 2 -> two match pulses, round_done after second; score=2, lives=3.
//  - Same pattern; event 3 as first event -> mismatch pulse, lives=2, expected returns to 1 after ALIGN+DECODE; then 1,2 -> round_done.
//  - LIVES=1, pattern=64'h2; event 4 -> mismatch, game_over=1, lives=0; later load ignored; reset -> lives=1, game_over=0.
//  - pattern=64'h3E (five 1s) -> decode_err=1, state ERR, busy=0, no match/mismatch; load 64'h2 clears decode_err.
//  - TIMEOUT=10, pattern=64'h2, no events -> mismatch exactly 10 cycles after entering WAIT_EVT; lives=2.
//  - pattern=0 -> round_done 1 cycle after ALIGN entry; score unchanged.
//  - Reset asserted mid-DECODE -> next cycle IDLE, busy=0, score=0.
//  - event_valid coincident with load -> event ignored.

Source files
------------

// File: rtl/sequence_checker.sv
// sequence_checker: round judge for the memory game.
// It latches the encoded target pattern and decodes it one symbol at a time.
// Each decoded symbol is checked against the player's event code.
// It keeps the score and the remaining lives, and flags round completion and game over.
//
// Pattern encoding (bit 63 is consumed first): leading zeros, then for each
// symbol n ones (n = 1..4) followed by a single zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, nothing latched
// ALIGN    | skipping leading zeros of the shift register
// DECODE   | counting the ones of the current symbol
// WAIT_EVT | symbol decoded, waiting for the player's event
// DONE     | whole pattern matched (or empty), hold until load
// OVER     | lives exhausted, hold until reset (load ignored)
// ERR      | malformed pattern (run of 5+ ones), hold until load
module sequence_checker #(
    parameter int LIVES   = 3,
    parameter int TIMEOUT = 0,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [63:0]        pattern,
    input  logic               event_valid,
    input  logic [2:0]         event_code,
    output logic [2:0]         expected,
    output logic               busy,
    output logic               match,
    output logic               mismatch,
    output logic               round_done,
    output logic               game_over,
    output logic               decode_err,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        DECODE,
        WAIT_EVT,
        DONE,
        OVER,
        ERR
    } state_t;

    // The wait timer counts down from TIMEOUT-1 and fires on reaching zero,
    // which lands the mismatch exactly TIMEOUT cycles after entering WAIT_EVT.
    localparam int                TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic              TMR_EN   = (TIMEOUT != 0);

    state_t             state;
    logic [63:0]        saved;
    logic [63:0]        sh;
    logic [2:0]         ones;
    logic [TMR_W-1:0]   tmr;

    logic               evt_seen;
    logic               evt_hit;
    logic               tmr_fire;

    // Code 0 is not a player event; an event beats a timeout in the same cycle.
    assign evt_seen = event_valid && (event_code != 3'd0);
    assign evt_hit  = evt_seen && (event_code == expected);
    assign tmr_fire = TMR_EN && !evt_seen && (tmr == '0);

    assign busy = (state == ALIGN) || (state == DECODE) || (state == WAIT_EVT);

    // Round FSM with registered pulses, score and lives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            saved      <= '0;
            sh         <= '0;
            ones       <= '0;
            tmr        <= '0;
            expected   <= '0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            round_done <= 1'b0;
            game_over  <= 1'b0;
            decode_err <= 1'b0;
            score      <= '0;
            lives      <= 2'(LIVES);
        end else begin
            match      <= 1'b0;
            mismatch   <= 1'b0;
            round_done <= 1'b0;

            if (load && (state != OVER)) begin
                // A new round restarts decoding but keeps score and lives.
                saved      <= pattern;
                sh         <= pattern;
                ones       <= '0;
                decode_err <= 1'b0;
                expected   <= '0;
                state      <= ALIGN;
            end else begin
                case (state)
                    ALIGN: begin
                        if (sh == '0) begin
                            round_done <= 1'b1;
                            state      <= DONE;
                        end else if (!sh[63]) begin
                            sh <= sh << 1;
                        end else begin
                            state <= DECODE;
                        end
                    end

                    DECODE: begin
                        sh <= sh << 1;
                        if (sh[63]) begin
                            if (ones == 3'd4) begin
                                decode_err <= 1'b1;
                                state      <= ERR;
                            end else begin
                                ones <= ones + 3'd1;
                            end
                        end else begin
                            expected <= ones;
                            ones     <= '0;
                            tmr      <= TMR_LOAD;
                            state    <= WAIT_EVT;
                        end
                    end

                    WAIT_EVT: begin
                        if (evt_hit) begin
                            match    <= 1'b1;
                            expected <= '0;
                            if (score != {SCORE_W{1'b1}}) begin
                                score <= score + SCORE_W'(1);
                            end
                            if (sh == '0) begin
                                round_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                state <= DECODE;
                            end
                        end else if (evt_seen || tmr_fire) begin
                            mismatch <= 1'b1;
                            expected <= '0;
                            if (lives == 2'd1) begin
                                lives     <= 2'd0;
                                game_over <= 1'b1;
                                state     <= OVER;
                            end else begin
                                // Replay the round from its first symbol.
                                lives <= lives - 2'd1;
                                sh    <= saved;
                                state <= ALIGN;
                            end
                        end else if (TMR_EN) begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end

                    IDLE, DONE, OVER, ERR: begin
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Testbench for sequence_checker: directed scenarios plus randomized rounds,
// with a symbol-list reference model feeding a scoreboard of expected outputs.
module tb_sequence_checker;

    localparam int LIVES   = 3;
    localparam int TIMEOUT = 10;
    localparam int SCORE_W = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               load = 1'b0;
    logic [63:0]        pattern = '0;
    logic               event_valid = 1'b0;
    logic [2:0]         event_code = '0;
    logic [2:0]         expected;
    logic               busy;
    logic               match;
    logic               mismatch;
    logic               round_done;
    logic               game_over;
    logic               decode_err;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;

    typedef struct packed {
        logic       m;
        logic       mm;
        logic       rd;
        logic       go;
        logic       de;
        logic [7:0] sc;
        logic [1:0] lv;
    } rec_t;

    rec_t        exp_q[$];
    int          sym_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_score = 0;
    int          m_lives = LIVES;
    bit          coin = 1'b0;
    logic [2:0]  coin_code = '0;

    sequence_checker #(
        .LIVES   (LIVES),
        .TIMEOUT (TIMEOUT),
        .SCORE_W (SCORE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .pattern     (pattern),
        .event_valid (event_valid),
        .event_code  (event_code),
        .expected    (expected),
        .busy        (busy),
        .match       (match),
        .mismatch    (mismatch),
        .round_done  (round_done),
        .game_over   (game_over),
        .decode_err  (decode_err),
        .score       (score),
        .lives       (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(bit m, bit mm, bit rd, bit de);
        rec_t r;
        r.m  = m;
        r.mm = mm;
        r.rd = rd;
        r.go = (m_lives == 0);
        r.de = de;
        r.sc = 8'(m_score);
        r.lv = 2'(m_lives);
        exp_q.push_back(r);
    endtask

    // Monitor: every output pulse (or decode_err rising) must match the queue head.
    initial begin
        bit   dprev;
        rec_t got;
        rec_t want;
        dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && (match || mismatch || round_done || (decode_err && !dprev))) begin
                got.m  = match;
                got.mm = mismatch;
                got.rd = round_done;
                got.go = game_over;
                got.de = decode_err;
                got.sc = score;
                got.lv = lives;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h want no output", got);
                end else begin
                    want = exp_q.pop_front();
                    check("scoreboard", got, want);
                end
            end
            dprev = decode_err;
        end
    end

    task automatic do_load(logic [63:0] p, logic cv, logic [2:0] cc);
        pattern     = p;
        load        = 1'b1;
        event_valid = cv;
        event_code  = cc;
        @(negedge clk);
        load        = 1'b0;
        event_valid = 1'b0;
        event_code  = '0;
    endtask

    task automatic send_event(logic [2:0] code);
        event_valid = 1'b1;
        event_code  = code;
        @(negedge clk);
        event_valid = 1'b0;
        event_code  = '0;
    endtask

    task automatic wait_expected(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (expected != 3'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_expected: got expected=0 for 150 cycles want nonzero symbol");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=1 for 150 cycles want 0");
        end
    endtask

    task automatic hit(bit last);
        if (m_score < 255) m_score++;
        push(1'b1, 1'b0, last, 1'b0);
    endtask

    task automatic miss();
        m_lives--;
        push(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Called when expected has just appeared: count cycles to the mismatch.
    task automatic expect_timeout();
        int tk;
        tk = 0;
        miss();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            tk = k;
            if (mismatch) break;
        end
        check("timeout_latency", tk, TIMEOUT);
    endtask

    task automatic gen_round(int min_m, int max_m, output logic [63:0] p);
        int m;
        int n;
        int len;
        p   = '0;
        len = 0;
        sym_q.delete();
        m = $urandom_range(max_m, min_m);
        for (int i = 0; i < m; i++) begin
            n = $urandom_range(4, 1);
            sym_q.push_back(n);
            repeat (n) p = {p[62:0], 1'b1};
            p   = {p[62:0], 1'b0};
            len = len + n + 1;
        end
        p = p << $urandom_range(64 - len, 0);
    endtask

    task automatic play_body(bit allow_err, output bit abandoned);
        int         idx;
        int         act;
        bit         ok;
        logic [2:0] code;
        abandoned = 1'b0;
        idx = 0;
        if (sym_q.size() == 0) begin
            push(1'b0, 1'b0, 1'b1, 1'b0);
            wait_idle();
            return;
        end
        forever begin
            wait_expected(ok);
            if (!ok) return;
            check("expected_symbol", expected, sym_q[idx]);
            act = allow_err ? $urandom_range(99, 0) : 0;
            if (act >= 96) begin
                abandoned = 1'b1;
                coin_code = 3'(sym_q[idx]);
                return;
            end
            if (act >= 86) begin
                expect_timeout();
                idx = 0;
                if (m_lives == 0) return;
                continue;
            end
            repeat ($urandom_range(6, 0)) begin
                event_valid = 1'($urandom_range(1, 0));
                event_code  = '0;
                @(negedge clk);
            end
            event_valid = 1'b0;
            if (act < 72) begin
                code = 3'(sym_q[idx]);
                idx++;
                hit(idx == sym_q.size());
                send_event(code);
                if (idx == sym_q.size()) begin
                    wait_idle();
                    return;
                end
            end else begin
                do code = 3'($urandom_range(7, 1)); while (code == sym_q[idx]);
                miss();
                send_event(code);
                idx = 0;
                if (m_lives == 0) return;
            end
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        load        = 1'b0;
        event_valid = 1'b0;
        event_code  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_expected", expected, 0);
        check("reset_score", score, 0);
        check("reset_lives", lives, LIVES);
        check("reset_game_over", game_over, 0);
        check("reset_decode_err", decode_err, 0);
        check("reset_pulses", {match, mismatch, round_done}, 0);
        m_score = 0;
        m_lives = LIVES;
        coin    = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit          ab;
        bit          ok;
        logic [63:0] p;

        apply_reset();

        // Two-symbol pattern answered correctly.
        sym_q.delete();
        sym_q.push_back(1);
        sym_q.push_back(2);
        do_load(64'h16, 1'b0, 3'd0);
        play_body(1'b0, ab);
        check("score_after_h16", score, 2);
        check("lives_after_h16", lives, 3);

        // Wrong first event, replay, then correct answers.
        do_load(64'h16, 1'b0, 3'd0);
        wait_expected(ok);
        check("first_symbol", expected, 1);
        miss();
        send_event(3'd3);
        check("lives_after_miss", lives, 2);
        play_body(1'b0, ab);

        // Empty pattern: round_done one cycle after ALIGN entry.
        sym_q.delete();
        push(1'b0, 1'b0, 1'b1, 1'b0);
        do_load(64'h0, 1'b0, 3'd0);
        check("empty_rd_early", round_done, 0);
        @(negedge clk);
        check("empty_rd", round_done, 1);
        check("empty_score", score, m_score);

        // Malformed pattern: five ones.
        push(1'b0, 1'b0, 1'b0, 1'b1);
        do_load(64'h3E, 1'b0, 3'd0);
        wait_idle();
        check("err_busy", busy, 0);
        check("err_flag", decode_err, 1);
        sym_q.delete();
        sym_q.push_back(1);
        do_load(64'h2, 1'b0, 3'd0);
        check("err_cleared", decode_err, 0);
        play_body(1'b0, ab);

        // Timeout with no events.
        do_load(64'h2, 1'b0, 3'd0);
        wait_expected(ok);
        expect_timeout();
        check("lives_after_timeout", lives, m_lives);
        play_body(1'b0, ab);

        // Event coincident with load while waiting must be ignored.
        do_load(64'h2, 1'b0, 3'd0);
        wait_expected(ok);
        do_load(64'h2, 1'b1, 3'd1);
        play_body(1'b0, ab);

        // Reset in the middle of decoding.
        do_load(64'hF000_0000_0000_0000, 1'b0, 3'd0);
        @(negedge clk);
        check("decode_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_score", score, 0);
        check("mid_reset_lives", lives, LIVES);
        check("mid_reset_expected", expected, 0);
        m_score = 0;
        m_lives = LIVES;
        reset   = 1'b1;
        @(negedge clk);

        // Long clean rounds drive the score into saturation.
        for (int r = 0; r < 60; r++) begin
            gen_round(6, 10, p);
            do_load(p, 1'b0, 3'd0);
            play_body(1'b0, ab);
            if (m_score >= 255 && r > 0 && sym_q.size() > 0 && score == 8'hFF) break;
        end
        gen_round(2, 4, p);
        do_load(p, 1'b0, 3'd0);
        play_body(1'b0, ab);
        check("score_saturated", score, 255);

        // Randomized rounds with errors, timeouts, abandons and game overs.
        ab = 1'b0;
        for (int r = 0; r < 50; r++) begin
            gen_round(0, 8, p);
            if (coin) do_load(p, 1'b1, coin_code);
            else      do_load(p, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
            coin = 1'b0;
            play_body(1'b1, ab);
            if (ab) coin = 1'b1;
            if (m_lives == 0) begin
                check("over_flag", game_over, 1);
                check("over_lives", lives, 0);
                do_load(64'h2, 1'b1, 3'd1);
                repeat (5) @(negedge clk);
                check("over_load_ignored_busy", busy, 0);
                check("over_hold", game_over, 1);
                apply_reset();
            end
        end
        if (coin) begin
            gen_round(1, 4, p);
            do_load(p, 1'b1, coin_code);
            play_body(1'b0, ab);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
